addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit: the next-generation replacement for the plain two-input subtractor in the general HDL library.
- Each sample selects add or subtract and carries a valid flag.
- Results are exact internally, then reduced to a chosen output width by wrapping or saturating. Overflow is flagged per sample and as a sticky status bit.
- Used in DSP datapaths (accumulator front-ends, difference stages) where registering is needed and stall (ce) control is required.

Parameters:
- A_WIDTH, 8, width of input a.
- B_WIDTH, 8, width of input b.
- A_IS_SIGNED, "TRUE", "TRUE" means a is two's complement; "FALSE" means a is unsigned.
- B_IS_SIGNED, "TRUE", same meaning for b.
- OUT_WIDTH, 9, width of c; legal range is 2 to FULL_WIDTH.
- SATURATE, "FALSE", "TRUE" clamps out-of-range results to the min/max of OUT_WIDTH; "FALSE" wraps them (keeps the low bits).
- LATENCY, 2, register stages from input to output; legal range is 1 to 8.
- USE_DSP, "NO", synthesis hint placed on the arithmetic node.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; 0 stalls the whole pipeline
- din_valid  in  1  a, b and sub are valid this cycle
- sub  in  1  1 computes a-b; 0 computes a+b
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- dout_valid  out  1  c is valid
- c  out  OUT_WIDTH  signed result, always two's complement
- ovf  out  1  this result overflowed OUT_WIDTH (aligned with c)
- ovf_sticky  out  1  latched overflow
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Reset and clocking: one clock domain (clk). rst is synchronous and active-high.
- Internal width: FULL_WIDTH = max(A_WIDTH, B_WIDTH) + 2, which is exact for any signedness mix and either operation.
- Extension: a and b are extended to FULL_WIDTH, sign-extended if signed and zero-extended if unsigned.
- Exact result: r = a_ext + b_ext when sub=0; r = a_ext - b_ext when sub=1. r never overflows.
- Range check: in_range is true when r lies in [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Wrap mode (SATURATE="FALSE"): c = r[OUT_WIDTH-1:0].
- Saturate mode (SATURATE="TRUE"): out of range positive gives 0 followed by all ones (max); out of range negative gives 1 followed by all zeros (min).
- ovf = !in_range, reported in both modes.
- Pipeline:
  - Exactly LATENCY registers between the inputs and {dout_valid, c, ovf}.
  - Stage 1 registers the extended operands and the sub bit. The arithmetic is placed after stage 1; range/saturation logic follows it.
  - Any remaining stages are plain delay registers.
  - With LATENCY=1 the single register sits at the output and all logic is combinational ahead of it.
- ce and stalls:
  - ce=1: every stage advances.
  - ce=0: every stage holds, including the valid bits. Outputs stay stable.
  - Latency counts ce=1 cycles only.
- Valid handling:
  - din_valid propagates with its data.
  - When dout_valid=0, c and ovf are don't-care for the consumer but must not be X after reset.
  - Bubbles (din_valid=0) pass through without reordering.
- ovf_sticky:
  - Set on any cycle where dout_valid=1, ovf=1 and ce=1.
  - Cleared by ovf_clr; the clear takes effect on the next edge and is not gated by ce.
  - If set and clear happen in the same cycle, set wins.
- Reset:
  - On rst=1 at a clk edge, every pipeline register is cleared to 0 (valid, data, sub), and ovf_sticky is cleared to 0.
  - So after reset dout_valid=0, c=0, ovf=0.
  - rst overrides ce.
  - If reset lands mid-operation, in-flight samples are discarded and no dout_valid pulse is produced for them.
- Illegal parameters: OUT_WIDTH > FULL_WIDTH or a LATENCY outside its range must be caught at elaboration (generate-time error).

Test Plan:
1. Basic latency: defaults (8/8 signed, OUT=9, LATENCY=2, wrap). a=100, b=-28, sub=1 → c=128, ovf=0, dout_valid high exactly 2 cycles after din_valid. Then sub=0 with the same operands → c=72.
2. Saturation: SATURATE="TRUE", OUT_WIDTH=8, both inputs signed 8-bit.
   - a=127, b=-128, sub=1 (r=255) → c=127, ovf=1, ovf_sticky=1 from the next cycle.
   - a=-128, b=127, sub=1 → c=-128, ovf=1.
   - ovf_clr pulsed alone → ovf_sticky=0 on the following cycle.
3. Wrap and mixed signedness: A unsigned 8-bit, B signed 8-bit, OUT=8, wrap. a=255, b=-1, sub=1 → r=256, c=0x00, ovf=1. Then a=0, b=127, sub=1 → c=-127, ovf=0.
4. ce stall: LATENCY=3, back-to-back samples 1+1, 2+2, 3+3, with ce low for 4 cycles mid-stream → outputs 2, 4, 6 in order, no duplicates or losses, and each output held stable while ce=0.
5. Reset mid-flight: issue 2 valid samples, assert rst for 1 cycle before they emerge → no dout_valid for those samples, c=0, ovf_sticky=0. A new sample after reset emerges with the normal latency.
6. Sticky set/clear collision: apply ovf_clr in the same cycle that an overflowing result is output → ovf_sticky remains 1.

Source files
------------

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: exact internal arithmetic, wrap or saturate reduction to OUT_WIDTH,
// per-sample and sticky overflow flags, and a global clock-enable stall.
module addsub_pipe #(
  parameter int unsigned A_WIDTH     = 8,
  parameter int unsigned B_WIDTH     = 8,
  parameter string       A_IS_SIGNED = "TRUE",
  parameter string       B_IS_SIGNED = "TRUE",
  parameter int unsigned OUT_WIDTH   = 9,
  parameter string       SATURATE    = "FALSE",
  parameter int unsigned LATENCY     = 2,
  parameter string       USE_DSP     = "NO"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 din_valid,
  input  logic                 sub,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 dout_valid,
  output logic [OUT_WIDTH-1:0] c,
  output logic                 ovf,
  output logic                 ovf_sticky,
  input  logic                 ovf_clr
);

  localparam int unsigned MaxIn      = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
  localparam int unsigned FULL_WIDTH = MaxIn + 2;
  localparam int unsigned DlyDepth   = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int unsigned PayW       = OUT_WIDTH + 2;
  localparam bit          ASigned    = (A_IS_SIGNED == "TRUE");
  localparam bit          BSigned    = (B_IS_SIGNED == "TRUE");
  localparam bit          SatMode    = (SATURATE == "TRUE");

  // Elaboration-time parameter legality checks.
  if (A_WIDTH < 1 || B_WIDTH < 1) begin : g_bad_in_width
    $error("addsub_pipe: A_WIDTH and B_WIDTH must be at least 1");
  end
  if (OUT_WIDTH < 2 || OUT_WIDTH > FULL_WIDTH) begin : g_bad_out_width
    $error("addsub_pipe: OUT_WIDTH must lie in [2, FULL_WIDTH]");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("addsub_pipe: LATENCY must lie in [1, 8]");
  end
  if (A_IS_SIGNED != "TRUE" && A_IS_SIGNED != "FALSE") begin : g_bad_a_signed
    $error("addsub_pipe: A_IS_SIGNED must be \"TRUE\" or \"FALSE\"");
  end
  if (B_IS_SIGNED != "TRUE" && B_IS_SIGNED != "FALSE") begin : g_bad_b_signed
    $error("addsub_pipe: B_IS_SIGNED must be \"TRUE\" or \"FALSE\"");
  end
  if (SATURATE != "TRUE" && SATURATE != "FALSE") begin : g_bad_saturate
    $error("addsub_pipe: SATURATE must be \"TRUE\" or \"FALSE\"");
  end
  if (USE_DSP == "") begin : g_bad_use_dsp
    $error("addsub_pipe: USE_DSP must not be empty");
  end

  logic [FULL_WIDTH-1:0] a_ext;
  logic [FULL_WIDTH-1:0] b_ext;

  assign a_ext = {{(FULL_WIDTH - A_WIDTH){ASigned & a[A_WIDTH-1]}}, a};
  assign b_ext = {{(FULL_WIDTH - B_WIDTH){BSigned & b[B_WIDTH-1]}}, b};

  logic                  op_valid;
  logic                  op_sub;
  logic [FULL_WIDTH-1:0] op_a;
  logic [FULL_WIDTH-1:0] op_b;

  if (LATENCY > 1) begin : g_stage1
    logic                  s1_valid_q;
    logic                  s1_sub_q;
    logic [FULL_WIDTH-1:0] s1_a_q;
    logic [FULL_WIDTH-1:0] s1_b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_sub_q   <= 1'b0;
        s1_a_q     <= '0;
        s1_b_q     <= '0;
      end else if (ce) begin
        s1_valid_q <= din_valid;
        s1_sub_q   <= sub;
        s1_a_q     <= a_ext;
        s1_b_q     <= b_ext;
      end
    end

    assign op_valid = s1_valid_q;
    assign op_sub   = s1_sub_q;
    assign op_a     = s1_a_q;
    assign op_b     = s1_b_q;
  end else begin : g_no_stage1
    // Single-register build: all arithmetic sits ahead of the output register.
    assign op_valid = din_valid;
    assign op_sub   = sub;
    assign op_a     = a_ext;
    assign op_b     = b_ext;
  end

  (* use_dsp = USE_DSP *)
  logic [FULL_WIDTH-1:0] r;

  assign r = op_sub ? (op_a - op_b) : (op_a + op_b);

  // r fits OUT_WIDTH signed exactly when all bits from the OUT_WIDTH sign bit upward agree.
  logic [FULL_WIDTH-OUT_WIDTH:0] r_top;
  logic                          in_range;
  logic [OUT_WIDTH-1:0]          res_c;

  assign r_top    = r[FULL_WIDTH-1:OUT_WIDTH-1];
  assign in_range = (r_top == '0) || (r_top == '1);

  always_comb begin
    res_c = r[OUT_WIDTH-1:0];
    if (SatMode && !in_range) begin
      res_c = r[FULL_WIDTH-1] ? {1'b1, {(OUT_WIDTH - 1){1'b0}}}
                              : {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end
  end

  // Output delay line, one {valid, ovf, c} word per stage, newest in the low slot.
  logic [PayW-1:0]          res_word;
  logic [DlyDepth*PayW-1:0] dly_q;
  logic [DlyDepth*PayW-1:0] dly_d;

  assign res_word = {op_valid, ~in_range, res_c};

  if (DlyDepth == 1) begin : g_shift_one
    assign dly_d = res_word;
  end else begin : g_shift_many
    assign dly_d = {dly_q[(DlyDepth-1)*PayW-1:0], res_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
    end else if (ce) begin
      dly_q <= dly_d;
    end
  end

  assign {dout_valid, ovf, c} = dly_q[DlyDepth*PayW-1 -: PayW];

  logic sticky_q;

  // A set on the same edge as a clear takes priority; the clear ignores ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (ce && dout_valid && ovf) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: four differently-parameterised instances, directed vectors
// with hand-computed expectations queued at issue time and checked by per-instance monitors.
module tb_addsub_pipe;

  typedef struct {
    logic [8:0] c;
    logic       ovf;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  logic rst, rst0, ce0, ce1, ce2, ce3;
  logic v0, v1, v2, v3, s0, s1, s2, s3;
  logic clr0, clr1, clr2, clr3;
  logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3;
  logic dv0, dv1, dv2, dv3, o0, o1, o2, o3, st0, st1, st2, st3;
  logic [8:0] c0, c3;
  logic [7:0] c1, c2;

  // Defaults: 8/8 signed, OUT=9, LATENCY=2, wrap.
  addsub_pipe u0 (
    .clk(clk), .rst(rst0), .ce(ce0), .din_valid(v0), .sub(s0), .a(a0), .b(b0),
    .dout_valid(dv0), .c(c0), .ovf(o0), .ovf_sticky(st0), .ovf_clr(clr0)
  );

  addsub_pipe #(.OUT_WIDTH(8), .SATURATE("TRUE")) u1 (
    .clk(clk), .rst(rst), .ce(ce1), .din_valid(v1), .sub(s1), .a(a1), .b(b1),
    .dout_valid(dv1), .c(c1), .ovf(o1), .ovf_sticky(st1), .ovf_clr(clr1)
  );

  addsub_pipe #(.A_IS_SIGNED("FALSE"), .OUT_WIDTH(8)) u2 (
    .clk(clk), .rst(rst), .ce(ce2), .din_valid(v2), .sub(s2), .a(a2), .b(b2),
    .dout_valid(dv2), .c(c2), .ovf(o2), .ovf_sticky(st2), .ovf_clr(clr2)
  );

  addsub_pipe #(.LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .ce(ce3), .din_valid(v3), .sub(s3), .a(a3), .b(b3),
    .dout_valid(dv3), .c(c3), .ovf(o3), .ovf_sticky(st3), .ovf_clr(clr3)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  function automatic void cmp(string nm, exp_t e, logic [8:0] c, logic o);
    chk({nm, " c"}, c, e.c);
    chk({nm, " ovf"}, o, e.ovf);
    if (e.due >= 0) chk({nm, " latency"}, cyc, e.due);
  endfunction

  // Monitors: a result is consumed on the cycle its stage advances.
  always @(negedge clk) begin
    if (!rst0 && ce0 && dv0 === 1'b1) begin
      chk("u0 output expected", q0.size() > 0, 1);
      if (q0.size() > 0) cmp("u0", q0.pop_front(), c0, o0);
    end
  end

  always @(negedge clk) begin
    if (!rst && ce1 && dv1 === 1'b1) begin
      chk("u1 output expected", q1.size() > 0, 1);
      if (q1.size() > 0) cmp("u1", q1.pop_front(), {1'b0, c1}, o1);
    end
  end

  always @(negedge clk) begin
    if (!rst && ce2 && dv2 === 1'b1) begin
      chk("u2 output expected", q2.size() > 0, 1);
      if (q2.size() > 0) cmp("u2", q2.pop_front(), {1'b0, c2}, o2);
    end
  end

  always @(negedge clk) begin
    if (!rst && ce3 && dv3 === 1'b1) begin
      chk("u3 output expected", q3.size() > 0, 1);
      if (q3.size() > 0) cmp("u3", q3.pop_front(), c3, o3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 1'b0;
    v1 = 1'b0;
    v2 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [8:0] ec, input logic eo);
    exp_t e;
    e.c   = ec;
    e.ovf = eo;
    e.due = -1;
    case (u)
      0: begin a0 = a; b0 = b; s0 = s; v0 = 1'b1; e.due = cyc + 2; q0.push_back(e); end
      1: begin a1 = a; b1 = b; s1 = s; v1 = 1'b1; e.due = cyc + 2; q1.push_back(e); end
      2: begin a2 = a; b2 = b; s2 = s; v2 = 1'b1; e.due = cyc + 2; q2.push_back(e); end
      default: begin a3 = a; b3 = b; s3 = s; v3 = 1'b1; q3.push_back(e); end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst0 = 1'b1;
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1; ce3 = 1'b1;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0; clr3 = 1'b0;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    idle();
    repeat (3) tick();
    rst = 1'b0; rst0 = 1'b0;

    chk("reset u0 dout_valid", dv0, 0);
    chk("reset u0 c", c0, 0);
    chk("reset u0 ovf", o0, 0);
    chk("reset u0 sticky", st0, 0);
    chk("reset u1 c", c1, 0);
    chk("reset u3 dout_valid", dv3, 0);

    // Basic function and latency on defaults
    issue(0, 8'd100, 8'hE4, 1'b1, 9'd128, 1'b0); tick();
    issue(0, 8'd100, 8'hE4, 1'b0, 9'd72, 1'b0);  tick();
    issue(0, 8'h80, 8'h80, 1'b0, 9'h100, 1'b0);  tick();
    issue(0, 8'h7F, 8'h80, 1'b1, 9'h0FF, 1'b0);  tick();
    idle();
    repeat (4) tick();
    chk("u0 sticky stays clear", st0, 0);

    // Saturation and sticky behaviour
    issue(1, 8'h7F, 8'h80, 1'b1, 9'h07F, 1'b1); tick();
    issue(1, 8'h80, 8'h7F, 1'b1, 9'h080, 1'b1); tick();
    idle();
    chk("u1 sticky before set edge", st1, 0);
    tick();
    chk("u1 sticky set", st1, 1);
    issue(1, 8'd50, 8'd20, 1'b0, 9'd70, 1'b0);   tick();
    issue(1, 8'h9C, 8'h9C, 1'b0, 9'h080, 1'b1);  tick();
    idle();
    repeat (4) tick();
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("u1 sticky cleared", st1, 0);

    // Clear coinciding with an overflowing output: set must win
    issue(1, 8'h7F, 8'h80, 1'b1, 9'h07F, 1'b1); tick();
    idle(); tick();
    chk("u1 overflow at output", o1, 1);
    chk("u1 sticky clear before collision", st1, 0);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("u1 sticky set wins", st1, 1);
    tick();
    chk("u1 sticky held", st1, 1);
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    chk("u1 sticky cleared again", st1, 0);

    // Wrap with unsigned a, signed b
    issue(2, 8'hFF, 8'hFF, 1'b1, 9'h000, 1'b1); tick();
    issue(2, 8'h00, 8'h7F, 1'b1, 9'h081, 1'b0); tick();
    issue(2, 8'hC8, 8'h0A, 1'b0, 9'h0D2, 1'b1); tick();
    issue(2, 8'h64, 8'hCE, 1'b0, 9'h032, 1'b0); tick();
    idle();
    repeat (4) tick();

    // Stall mid-stream on the 3-stage instance
    issue(3, 8'd1, 8'd1, 1'b0, 9'd2, 1'b0); tick();
    issue(3, 8'd2, 8'd2, 1'b0, 9'd4, 1'b0); tick();
    issue(3, 8'd3, 8'd3, 1'b0, 9'd6, 1'b0); tick();
    idle();
    ce3 = 1'b0;
    repeat (4) begin
      tick();
      chk("u3 stalled dout_valid", dv3, 1);
      chk("u3 stalled c", c3, 9'd2);
    end
    ce3 = 1'b1;
    repeat (6) tick();

    // Reset with two samples in flight: neither may emerge
    a0 = 8'd5; b0 = 8'd6; s0 = 1'b0; v0 = 1'b1; tick();
    a0 = 8'd7; b0 = 8'd8; rst0 = 1'b1; tick();
    rst0 = 1'b0; v0 = 1'b0;
    chk("u0 post-reset dout_valid", dv0, 0);
    chk("u0 post-reset c", c0, 0);
    chk("u0 post-reset sticky", st0, 0);
    repeat (3) tick();
    chk("u0 no late pulse", dv0, 0);
    issue(0, 8'd10, 8'd3, 1'b1, 9'd7, 1'b0); tick();
    idle();
    repeat (4) tick();

    for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size() + q3.size()) > 0; i++) tick();
    chk("u0 scoreboard drained", q0.size(), 0);
    chk("u1 scoreboard drained", q1.size(), 0);
    chk("u2 scoreboard drained", q2.size(), 0);
    chk("u3 scoreboard drained", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
